alu_operand_stage: RTL and testbench

//  Operand-fetch pipeline stage directly upstream of alu16b.

---
 rtl/alu_operand_stage_pkg.sv | 35 +++
 rtl/alu_operand_stage_if.sv | 45 ++++
 rtl/alu_operand_stage_reg_file16.sv | 59 +++++
 rtl/alu_operand_stage.sv | 98 +++++++++
 tb/tb_alu_operand_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_operand_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_pkg
// Shared sizes, ALU opcode constants and the immediate extender that are used
// by the operand-fetch stage, its register file and the interface that joins
// it to the decoder and the alu16b execute stage.
// -----------------------------------------------------------------------------
package alu_operand_stage_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned IMM_W  = 8;

    // alu16b opcode encodings; the stage only passes op through
    typedef enum logic [OP_W-1:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_NAND = 4'd6,
        ALU_INV  = 4'd7
    } alu_op_e;

    // Widen the raw immediate to WIDTH bits, sign- or zero-extended
    function automatic logic [WIDTH-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                 input logic             sext);
        logic fill;
        fill = sext & imm[IMM_W-1];
        return {{(WIDTH-IMM_W){fill}}, imm};
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_if
// Bundles the decoder-side handshake, writeback port and ALU-side handshake of
// the operand-fetch stage.
//   master : decoder / writeback / execute side (drives instruction fields,
//            flush, writeback, out_ready; observes in_ready and outputs)
//   slave  : the operand stage itself
// -----------------------------------------------------------------------------
interface alu_operand_stage_if;
    import alu_operand_stage_pkg::*;

    // decoder side
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [IMM_W-1:0]  imm;
    logic              use_imm;
    logic              imm_sext;
    logic [OP_W-1:0]   op_in;
    logic              flush;
    // writeback side
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]  wb_data;
    // execute side
    logic              out_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic [OP_W-1:0]   op;

    modport master (
        output in_valid, rs_addr, rt_addr, imm, use_imm, imm_sext, op_in, flush,
        output wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, A, B, op
    );

    modport slave (
        input  in_valid, rs_addr, rt_addr, imm, use_imm, imm_sext, op_in, flush,
        input  wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, A, B, op
    );

endinterface

// File: rtl/alu_operand_stage_reg_file16.sv
// -----------------------------------------------------------------------------
// reg_file16
// Register file with two combinational read ports and one synchronous write
// port. r0 always reads zero and ignores writes. A write presented in the same
// cycle as a read of the same (non-zero) address is forwarded to the read port.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all regs)
//   ra_i / rdata_a_o    read port A address / data
//   rb_i / rdata_b_o    read port B address / data
//   we_i, wa_i, wd_i    write enable, address, data
// -----------------------------------------------------------------------------
module reg_file16
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned RF_WIDTH  = WIDTH,
    parameter int unsigned RF_NREGS  = NREGS,
    parameter int unsigned RF_ADDR_W = ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RF_ADDR_W-1:0] ra_i,
    output logic [RF_WIDTH-1:0]  rdata_a_o,
    input  logic [RF_ADDR_W-1:0] rb_i,
    output logic [RF_WIDTH-1:0]  rdata_b_o,
    input  logic                 we_i,
    input  logic [RF_ADDR_W-1:0] wa_i,
    input  logic [RF_WIDTH-1:0]  wd_i
);

    logic [RF_WIDTH-1:0] regs_q [RF_NREGS];
    logic                wr_ok;

    assign wr_ok = we_i && (wa_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RF_NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        if (ra_i != '0) begin
            rdata_a_o = (wr_ok && (wa_i == ra_i)) ? wd_i : regs_q[ra_i];
        end
    end

    always_comb begin
        rdata_b_o = '0;
        if (rb_i != '0) begin
            rdata_b_o = (wr_ok && (wa_i == rb_i)) ? wd_i : regs_q[rb_i];
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
// Operand-fetch stage feeding alu16b. Reads rs/rt from the register file
// (with writeback forwarding), picks B from rt or the extended immediate, and
// holds A/B/op in a one-entry output register under a valid/ready handshake.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        alu_operand_stage_if.slave:
//                in_valid/in_ready, rs_addr, rt_addr, imm, use_imm, imm_sext,
//                op_in, flush  - decoder side
//                wb_en, wb_addr, wb_data                - writeback
//                out_valid/out_ready, A, B, op          - execute side
// -----------------------------------------------------------------------------
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input logic               clk,
    input logic               rst,
    alu_operand_stage_if.slave bus
);

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;

    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] b_sel;
    logic             in_ready;
    logic             load;

    reg_file16 #(
        .RF_WIDTH  (WIDTH),
        .RF_NREGS  (NREGS),
        .RF_ADDR_W (ADDR_W)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .ra_i      (bus.rs_addr),
        .rdata_a_o (rs_data),
        .rb_i      (bus.rt_addr),
        .rdata_b_o (rt_data),
        .we_i      (bus.wb_en),
        .wa_i      (bus.wb_addr),
        .wd_i      (bus.wb_data)
    );

    assign b_sel = bus.use_imm ? ext_imm(bus.imm, bus.imm_sext) : rt_data;

    // Ready depends only on the output register, never on in_valid
    assign in_ready = (state_q == ST_EMPTY) || bus.out_ready;
    assign load     = bus.in_valid && in_ready && !bus.flush;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else if (load) begin
            // also covers drain+load: the new entry replaces the old one
            state_d = ST_FULL;
            a_d     = rs_data;
            b_d     = b_sel;
            op_d    = bus.op_in;
        end else if ((state_q == ST_FULL) && bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.op        = op_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_operand_stage_if bus();

    alu_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        in_valid;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [7:0]  imm;
        logic        use_imm;
        logic        sext;
        logic [3:0]  op;
        logic        wb_en;
        logic [3:0]  wb_addr;
        logic [15:0] wb_data;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } exp_t;

    vec_t tbl [14];
    exp_t sb [$];
    exp_t cur_exp;
    logic m_valid = 1'b0;
    logic mon_en  = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: sample mid-cycle, then model what the next edge does
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_ready;
            exp_ready = !m_valid || bus.out_ready;
            chk("out_valid", {15'd0, bus.out_valid}, {15'd0, m_valid});
            chk("in_ready", {15'd0, bus.in_ready}, {15'd0, exp_ready});
            if (m_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_entry", 16'd0, 16'd1);
                end else begin
                    chk("A", bus.A, sb[0].a);
                    chk("B", bus.B, sb[0].b);
                    chk("op", {12'd0, bus.op}, {12'd0, sb[0].op});
                end
            end
            if (rst || bus.flush) begin
                m_valid = 1'b0;
                sb.delete();
            end else begin
                if (m_valid && bus.out_ready) begin
                    void'(sb.pop_front());
                    m_valid = 1'b0;
                end
                if (bus.in_valid && exp_ready) begin
                    sb.push_back(cur_exp);
                    m_valid = 1'b1;
                end
            end
        end
    end

    task automatic drive(input vec_t v, input logic out_ready, input logic flush);
        @(posedge clk);
        #1;
        bus.in_valid  = v.in_valid;
        bus.rs_addr   = v.rs;
        bus.rt_addr   = v.rt;
        bus.imm       = v.imm;
        bus.use_imm   = v.use_imm;
        bus.imm_sext  = v.sext;
        bus.op_in     = v.op;
        bus.wb_en     = v.wb_en;
        bus.wb_addr   = v.wb_addr;
        bus.wb_data   = v.wb_data;
        bus.out_ready = out_ready;
        bus.flush     = flush;
        cur_exp       = '{a: v.exp_a, b: v.exp_b, op: v.op};
    endtask

    vec_t idle_v;
    vec_t v;

    initial begin
        idle_v = '{1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000};
        //          in_v  rs     rt     imm    use   sext  op     wb    wa     wd         expA       expB
        tbl[0]  = '{1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1,  16'hFFFF, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 4'd2,  16'h0001, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b1, 4'd1,  4'd2,  8'h00, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0,  16'h0000, 16'hFFFF, 16'h0001};
        tbl[3]  = '{1'b1, 4'd3,  4'd0,  8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3,  16'h7FFF, 16'h7FFF, 16'h0000};
        tbl[4]  = '{1'b1, 4'd3,  4'd3,  8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0,  16'h0000, 16'h7FFF, 16'h7FFF};
        tbl[5]  = '{1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0,  16'h1234, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b1, 4'd0,  4'd0,  8'h00, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0,  16'h0000, 16'h0000, 16'h0000};
        tbl[7]  = '{1'b1, 4'd1,  4'd0,  8'h80, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0,  16'h0000, 16'hFFFF, 16'hFF80};
        tbl[8]  = '{1'b1, 4'd1,  4'd0,  8'h80, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0,  16'h0000, 16'hFFFF, 16'h0080};
        tbl[9]  = '{1'b1, 4'd2,  4'd1,  8'h00, 1'b0, 1'b0, 4'd6, 1'b1, 4'd1,  16'h00AA, 16'h0001, 16'h00AA};
        tbl[10] = '{1'b1, 4'd1,  4'd2,  8'h7F, 1'b1, 1'b1, 4'd7, 1'b1, 4'd2,  16'h5555, 16'h00AA, 16'h007F};
        tbl[11] = '{1'b1, 4'd2,  4'd0,  8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0,  16'h0000, 16'h5555, 16'h0000};
        tbl[12] = '{1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 4'd15, 16'hBEEF, 16'h0000, 16'h0000};
        tbl[13] = '{1'b1, 4'd15, 4'd15, 8'h00, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0,  16'h0000, 16'hBEEF, 16'hBEEF};

        drive(idle_v, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_A", bus.A, 16'h0000);
        chk("rst_B", bus.B, 16'h0000);
        chk("rst_op", {12'd0, bus.op}, 16'd0);
        mon_en = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i], 1'b1, 1'b0);
        end
        drive(idle_v, 1'b1, 1'b0);
        drive(idle_v, 1'b1, 1'b0);
        @(negedge clk);
        chk("drain_keeps_A", bus.A, 16'hBEEF);
        chk("drain_keeps_B", bus.B, 16'hBEEF);

        // Stall: entry held 3 cycles while a new instruction waits and r1 is rewritten
        v = '{1'b1, 4'd2, 4'd1, 8'h00, 1'b0, 1'b0, 4'd3, 1'b0, 4'd0, 16'h0000, 16'h5555, 16'h00AA};
        drive(v, 1'b1, 1'b0);
        v = '{1'b1, 4'd15, 4'd15, 8'h00, 1'b0, 1'b0, 4'd1, 1'b1, 4'd1, 16'h1111, 16'hBEEF, 16'hBEEF};
        drive(v, 1'b0, 1'b0);
        v.wb_en = 1'b0;
        drive(v, 1'b0, 1'b0);
        drive(v, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall_A_stable", bus.A, 16'h5555);
        chk("stall_in_ready", {15'd0, bus.in_ready}, 16'd0);
        drive(v, 1'b0, 1'b1);
        drive(idle_v, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_out_valid", {15'd0, bus.out_valid}, 16'd0);

        // Flush beats load even with the output free
        v = '{1'b1, 4'd1, 4'd1, 8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 4'd0, 16'h0000, 16'h1111, 16'h1111};
        drive(v, 1'b1, 1'b1);
        drive(idle_v, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_beats_load", {15'd0, bus.out_valid}, 16'd0);

        // Reset while an entry is held; a write during reset is also dropped
        v = '{1'b1, 4'd1, 4'd2, 8'h00, 1'b0, 1'b0, 4'd6, 1'b0, 4'd0, 16'h0000, 16'h1111, 16'h5555};
        drive(v, 1'b0, 1'b0);
        v = '{1'b1, 4'd1, 4'd2, 8'h00, 1'b0, 1'b0, 4'd6, 1'b1, 4'd5, 16'hABCD, 16'h0000, 16'h0000};
        drive(v, 1'b0, 1'b0);
        rst = 1'b1;
        drive(idle_v, 1'b1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_A", bus.A, 16'h0000);
        chk("midrst_B", bus.B, 16'h0000);
        chk("midrst_op", {12'd0, bus.op}, 16'd0);
        v = '{1'b1, 4'd1, 4'd5, 8'h00, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000};
        drive(v, 1'b1, 1'b0);
        drive(idle_v, 1'b1, 1'b0);
        drive(idle_v, 1'b1, 1'b0);
        @(negedge clk);
        chk("sb_drained", sb.size() == 0 ? 16'd1 : 16'd0, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
